// File: rtl/vector_pkg.sv
// Shared types and constants for the multi-base control slice.
package vector_pkg;

    typedef enum logic [1:0] {
        ST_RESET     = 2'b00,
        ST_IDLE      = 2'b01,
        ST_EXPLODING = 2'b10,
        ST_NUKED     = 2'b11
    } base_state_t;

    localparam int ANIM_CNT_W = 4;

endpackage

// File: rtl/multi_base_control_base_slot.sv
// One base: hit compare, explosion counter and lifecycle FSM.
// Optional BASE_REARM_EN adds a rearm input that returns a NUKED base to IDLE.
module base_slot
    import vector_pkg::*;
#(
    parameter int                   OUT_WIDTH   = 8,
    parameter logic [OUT_WIDTH-1:0] X_BASE      = '0,
    parameter logic [OUT_WIDTH-1:0] Y_BASE      = '0,
    parameter int                   HIT_RADIUS  = 2,
    parameter int                   ANIM_FRAMES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OUT_WIDTH-1:0] xenemy,
    input  logic [OUT_WIDTH-1:0] yenemy,
    input  logic                 enemy_valid,
    input  logic                 frame_tick,
`ifdef BASE_REARM_EN
    input  logic                 rearm,
`endif
    output logic                 nuked,
    output logic                 exploding,
    output logic                 nuked_next
);

    localparam logic [OUT_WIDTH:0]    RADIUS    = HIT_RADIUS[OUT_WIDTH:0];
    localparam logic [ANIM_CNT_W-1:0] ANIM_LAST = ANIM_FRAMES[ANIM_CNT_W-1:0];

    base_state_t           state, state_next;
    logic [ANIM_CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic [OUT_WIDTH:0]    ex, ey, bx, by, dx, dy;
    logic                  hit;

    // One extra bit keeps the subtraction from wrapping across the coordinate range.
    assign ex  = {1'b0, xenemy};
    assign ey  = {1'b0, yenemy};
    assign bx  = {1'b0, X_BASE};
    assign by  = {1'b0, Y_BASE};
    assign dx  = (ex >= bx) ? ex - bx : bx - ex;
    assign dy  = (ey >= by) ? ey - by : by - ey;
    assign hit = enemy_valid && (dx <= RADIUS) && (dy <= RADIUS);

    assign cnt_inc = cnt + 4'd1;

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches inferred.
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            ST_RESET: state_next = ST_IDLE;
            ST_IDLE: begin
                if (hit) begin
                    state_next = ST_EXPLODING;
                    cnt_next   = '0;
                end
            end
            ST_EXPLODING: begin
                if (frame_tick) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == ANIM_LAST) state_next = ST_NUKED;
                end
            end
            ST_NUKED: begin
`ifdef BASE_REARM_EN
                if (rearm) state_next = ST_IDLE;
`endif
            end
            default: state_next = ST_RESET;
        endcase
    end

    assign nuked_next = (state_next == ST_EXPLODING) || (state_next == ST_NUKED);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all sequential state, so update order never matters.
        if (rst) begin
            state     <= ST_RESET;
            cnt       <= '0;
            nuked     <= 1'b0;
            exploding <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            nuked     <= nuked_next;
            exploding <= (state_next == ST_EXPLODING);
        end
    end

endmodule

// File: rtl/multi_base_control.sv
// Top level: N_BASES independent base slots plus the intact-base count.
// Define BASE_REARM_EN to add the rearm input.
module multi_base_control
    import vector_pkg::*;
#(
    parameter int                           OUT_WIDTH   = 8,
    parameter int                           N_BASES     = 4,
    parameter logic [N_BASES*OUT_WIDTH-1:0] X_BASES     = '0,
    parameter logic [N_BASES*OUT_WIDTH-1:0] Y_BASES     = '0,
    parameter int                           HIT_RADIUS  = 2,
    parameter int                           ANIM_FRAMES = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [OUT_WIDTH-1:0]         xenemy,
    input  logic [OUT_WIDTH-1:0]         yenemy,
    input  logic                         enemy_valid,
    input  logic                         frame_tick,
`ifdef BASE_REARM_EN
    input  logic [N_BASES-1:0]           rearm,
`endif
    output logic [N_BASES-1:0]           base_nuked,
    output logic [N_BASES-1:0]           base_exploding,
    output logic [$clog2(N_BASES+1)-1:0] bases_left,
    output logic                         all_nuked
);

    localparam int CW = $clog2(N_BASES + 1);

    logic [N_BASES-1:0] nuked_next;
    logic [CW-1:0]      nuked_cnt;

    for (genvar i = 0; i < N_BASES; i++) begin : g_base
        base_slot #(
            .OUT_WIDTH   (OUT_WIDTH),
            .X_BASE      (X_BASES[i*OUT_WIDTH +: OUT_WIDTH]),
            .Y_BASE      (Y_BASES[i*OUT_WIDTH +: OUT_WIDTH]),
            .HIT_RADIUS  (HIT_RADIUS),
            .ANIM_FRAMES (ANIM_FRAMES)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .xenemy      (xenemy),
            .yenemy      (yenemy),
            .enemy_valid (enemy_valid),
            .frame_tick  (frame_tick),
`ifdef BASE_REARM_EN
            .rearm       (rearm[i]),
`endif
            .nuked       (base_nuked[i]),
            .exploding   (base_exploding[i]),
            .nuked_next  (nuked_next[i])
        );
    end

    // Counting the next-state flags lets the count register on the same edge as base_nuked.
    always_comb begin
        nuked_cnt = '0;
        for (int i = 0; i < N_BASES; i++) nuked_cnt = nuked_cnt + CW'(nuked_next[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bases_left <= CW'(N_BASES);
            all_nuked  <= 1'b0;
        end else begin
            bases_left <= CW'(N_BASES) - nuked_cnt;
            all_nuked  <= (nuked_cnt == CW'(N_BASES));
        end
    end

endmodule

// File: doc/multi_base_control.md
MULTI_BASE_CONTROL -- requirements
Module: multi_base_control

Interface
REQ-001 The module SHALL have parameter OUT_WIDTH, default 8, setting the coordinate width in bits.
REQ-002 The module SHALL have parameter N_BASES, default 4, setting the number of bases (1..16).
REQ-003 The module SHALL have parameter X_BASES, default all zero, as N_BASES*OUT_WIDTH flattened base X coordinates, base i in bits [i*OUT_WIDTH +: OUT_WIDTH].
REQ-004 The module SHALL have parameter Y_BASES, default all zero, as base Y coordinates in the same layout as X_BASES.
REQ-005 The module SHALL have parameter HIT_RADIUS, default 2, as the inclusive per-axis hit tolerance in pixels.
REQ-006 The module SHALL have parameter ANIM_FRAMES, default 3, as the explosion duration in frame_tick pulses (1..15).
REQ-007 The module SHALL have port clk, input, 1 bit: the system clock.
REQ-008 The module SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-009 The module SHALL have port xenemy, input, OUT_WIDTH bits: enemy X coordinate, unsigned.
REQ-010 The module SHALL have port yenemy, input, OUT_WIDTH bits: enemy Y coordinate, unsigned.
REQ-011 The module SHALL have port enemy_valid, input, 1 bit: the enemy coordinates are live this cycle.
REQ-012 The module SHALL have port frame_tick, input, 1 bit: a one-cycle pulse per video frame.
REQ-013 The module SHALL have port base_nuked, output, N_BASES bits: bit i is high when base i is exploding or destroyed.
REQ-014 The module SHALL have port base_exploding, output, N_BASES bits: bit i is high only during the explosion of base i.
REQ-015 The module SHALL have port bases_left, output, $clog2(N_BASES+1) bits: the count of intact bases.
REQ-016 The module SHALL have port all_nuked, output, 1 bit: high when bases_left equals 0.

Function
REQ-017 Each base SHALL run an independent FSM with states RESET, IDLE, EXPLODING and NUKED.
REQ-018 RESET SHALL go to IDLE unconditionally after one cycle.
REQ-019 IDLE SHALL go to EXPLODING when enemy_valid is high, |xenemy-X_BASES[i]| <= HIT_RADIUS and |yenemy-Y_BASES[i]| <= HIT_RADIUS.
REQ-020 The differences in the hit test SHALL be computed OUT_WIDTH+1 bits wide with no wrap-around, so coordinate 0 is never near coordinate 2^OUT_WIDTH-1.
REQ-021 On entry to EXPLODING a 4-bit animation counter SHALL clear to 0, and a frame_tick in the entry cycle SHALL not be counted.
REQ-022 In EXPLODING each frame_tick SHALL increment the counter, and the FSM SHALL go to NUKED on the tick that makes the counter equal ANIM_FRAMES.
REQ-023 NUKED SHALL be terminal, except as REQ-031 allows.
REQ-024 Hits on a base already in EXPLODING or NUKED SHALL be ignored.
REQ-025 Several bases hit in the same cycle SHALL all transition in that cycle.
REQ-026 All outputs SHALL be registered and SHALL reflect the new state in the cycle after the clock edge that samples the hit or tick.
REQ-027 bases_left SHALL equal N_BASES minus the popcount of base_nuked, and SHALL be registered alongside it.
REQ-028 bases_left SHALL never underflow.

Reset
REQ-029 While rst is high, all FSMs SHALL go to RESET, counters SHALL clear, base_nuked and base_exploding SHALL be 0, bases_left SHALL be N_BASES and all_nuked SHALL be 0.
REQ-030 An rst assertion during an explosion SHALL abort it with no residual state, and normal hit detection SHALL resume two cycles after rst deasserts.

Configuration
REQ-031 With macro BASE_REARM_EN defined, the module SHALL add input rearm (N_BASES bits), and rearm[i] high SHALL move base i from NUKED to IDLE on the next edge.
REQ-032 rearm[i] SHALL be ignored in RESET, IDLE and EXPLODING.
REQ-033 If rearm[i] and a hit on base i occur in the same cycle, the base SHALL go to IDLE and the hit SHALL be ignored.
REQ-034 Without BASE_REARM_EN, the rearm port SHALL not exist and NUKED SHALL be terminal.

Structure
REQ-035 The base FSM state typedef (base_state_t, 2-bit encoding) SHALL live in vector_pkg.
REQ-036 The per-base FSM, counter and hit compare SHALL be one sub-module, base_slot, instantiated N_BASES times by generate.
REQ-037 The top level SHALL contain only the base_slot instances, the popcount logic and all_nuked.

Verification (N_BASES=4, X_BASES={10,60,110,160}, Y_BASES all 200, HIT_RADIUS=2, ANIM_FRAMES=3)
REQ-038 Bench: enemy (62,199) with valid, one cycle -> next cycle base_nuked=4'b0010, base_exploding=4'b0010, bases_left=3.
REQ-039 Bench: after REQ-038, three frame_tick pulses -> base_exploding[1] drops the cycle after the 3rd tick, and base_nuked[1] stays 1.
REQ-040 Bench: enemy (63,200) or (60,200) with valid=0 -> no change, with bases_left=4.
REQ-041 Bench: enemy (0,200) with a base at X=254, OUT_WIDTH=8 -> no hit, with no wrap.
REQ-042 Bench: hit all four bases in sequence -> all_nuked=1 and bases_left=0, and further hits leave these unchanged.
REQ-043 Bench: rst mid-explosion -> all outputs at reset values.
REQ-044 Bench, BASE_REARM_EN: rearm[1]=1 on a NUKED base -> base_nuked[1]=0 and bases_left increments.
